// File: rtl/icache_dataram_sched.sv
// icache_dataram_sched
//
// Scheduler for the single-ported icache data SRAM. Arbitrates MSHR read
// requests against downstream linefill write bursts, sequences each burst
// beat by beat, blocks reads to the line being filled, and delivers the read
// txnid aligned with SRAM output data.
//
// Optional feature macro: ICACHE_DATARAM_HAZARD_CHK_EN
//   defined   -> during a burst, reads to the line being filled are held
//   undefined -> no hazard comparator; FILL-state reads go whenever lf_vld_i=0
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_vld_i / rd_rdy_o        read request handshake
//   rd_way_i/index_i/txnid_i   read target and transaction id
//   lf_vld_i / lf_rdy_o        linefill beat handshake
//   lf_way_i, lf_index_i       fill target (sampled on the first beat)
//   lf_data_i                  beat payload
//   ram_en_o, ram_we_o         SRAM enable / write enable
//   ram_way_o/index_o/beat_o   SRAM address (beat = write beat select)
//   ram_wdata_o                SRAM write data
//   rsp_vld_o, rsp_txnid_o     read data valid sideband
//   lf_done_o/_way_o/_index_o  registered line-complete pulse

module icache_dataram_sched #(
  parameter int WAY_NUM         = 2,
  parameter int INDEX_WIDTH     = 7,
  parameter int TXNID_WIDTH     = 8,
  parameter int BEAT_NUM        = 4,
  parameter int BEAT_DATA_WIDTH = 128,
  parameter int RD_LAT          = 1,
  parameter int STARVE_MAX      = 8,
  localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int BEAT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_vld_i,
  output logic                       rd_rdy_o,
  input  logic [WAY_W-1:0]           rd_way_i,
  input  logic [INDEX_WIDTH-1:0]     rd_index_i,
  input  logic [TXNID_WIDTH-1:0]     rd_txnid_i,
  input  logic                       lf_vld_i,
  output logic                       lf_rdy_o,
  input  logic [WAY_W-1:0]           lf_way_i,
  input  logic [INDEX_WIDTH-1:0]     lf_index_i,
  input  logic [BEAT_DATA_WIDTH-1:0] lf_data_i,
  output logic                       ram_en_o,
  output logic                       ram_we_o,
  output logic [WAY_W-1:0]           ram_way_o,
  output logic [INDEX_WIDTH-1:0]     ram_index_o,
  output logic [BEAT_W-1:0]          ram_beat_o,
  output logic [BEAT_DATA_WIDTH-1:0] ram_wdata_o,
  output logic                       rsp_vld_o,
  output logic [TXNID_WIDTH-1:0]     rsp_txnid_o,
  output logic                       lf_done_o,
  output logic [WAY_W-1:0]           lf_done_way_o,
  output logic [INDEX_WIDTH-1:0]     lf_done_index_o
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {S_IDLE, S_FILL} state_t;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [SC_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic [WAY_W-1:0]       fill_way_q, fill_way_d;
  logic [INDEX_WIDTH-1:0] fill_index_q, fill_index_d;
  logic                   done_q, done_d;
  logic [WAY_W-1:0]       done_way_q, done_way_d;
  logic [INDEX_WIDTH-1:0] done_index_q, done_index_d;

  logic [RD_LAT-1:0]      rsp_vld_q;
  logic [TXNID_WIDTH-1:0] rsp_txnid_q [RD_LAT];

  logic starved;
  logic hazard;
  logic last_beat;
  logic rd_gnt;
  logic lf_gnt;

  assign starved   = (starve_cnt_q >= SC_W'(STARVE_MAX));
  assign last_beat = (beat_cnt_q == BEAT_W'(BEAT_NUM - 1));

`ifdef ICACHE_DATARAM_HAZARD_CHK_EN
  assign hazard = (rd_way_i == fill_way_q) && (rd_index_i == fill_index_q);
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    fill_way_d   = fill_way_q;
    fill_index_d = fill_index_q;
    done_d       = 1'b0;
    done_way_d   = '0;
    done_index_d = '0;
    rd_rdy_o     = 1'b0;
    lf_rdy_o     = 1'b0;
    rd_gnt       = 1'b0;
    lf_gnt       = 1'b0;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_way_o    = '0;
    ram_index_o  = '0;
    ram_beat_o   = '0;
    ram_wdata_o  = '0;

    case (state_q)
      S_IDLE: begin
        // Reads win a contended cycle until the pending burst start has
        // been starved STARVE_MAX times.
        lf_rdy_o = !rd_vld_i || starved;
        rd_rdy_o = !(lf_vld_i && starved);
      end
      S_FILL: begin
        lf_rdy_o = 1'b1;
        rd_rdy_o = !lf_vld_i && !hazard;
      end
      default: ;
    endcase

    lf_gnt = lf_vld_i && lf_rdy_o;
    rd_gnt = rd_vld_i && rd_rdy_o;

    if (lf_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_beat_o  = beat_cnt_q;
      ram_wdata_o = lf_data_i;
      // The first beat has not been latched yet, so it addresses the SRAM
      // from the live request fields.
      if (state_q == S_IDLE) begin
        ram_way_o    = lf_way_i;
        ram_index_o  = lf_index_i;
        fill_way_d   = lf_way_i;
        fill_index_d = lf_index_i;
      end else begin
        ram_way_o   = fill_way_q;
        ram_index_o = fill_index_q;
      end
      if (last_beat) begin
        beat_cnt_d   = '0;
        state_d      = S_IDLE;
        done_d       = 1'b1;
        done_way_d   = ram_way_o;
        done_index_d = ram_index_o;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        state_d    = S_FILL;
      end
    end else if (rd_gnt) begin
      ram_en_o    = 1'b1;
      ram_way_o   = rd_way_i;
      ram_index_o = rd_index_i;
    end

    if (lf_vld_i && !lf_gnt) begin
      if (!starved) starve_cnt_d = starve_cnt_q + SC_W'(1);
    end else begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      fill_way_q   <= '0;
      fill_index_q <= '0;
      done_q       <= 1'b0;
      done_way_q   <= '0;
      done_index_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      fill_way_q   <= fill_way_d;
      fill_index_q <= fill_index_d;
      done_q       <= done_d;
      done_way_q   <= done_way_d;
      done_index_q <= done_index_d;
    end
  end

  // Read response pipeline: RD_LAT stages matching the SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rsp_txnid_q[i] <= '0;
    end else begin
      rsp_vld_q[0]   <= rd_gnt;
      rsp_txnid_q[0] <= rd_gnt ? rd_txnid_i : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        rsp_vld_q[i]   <= rsp_vld_q[i-1];
        rsp_txnid_q[i] <= rsp_txnid_q[i-1];
      end
    end
  end

  assign rsp_vld_o       = rsp_vld_q[RD_LAT-1];
  assign rsp_txnid_o     = rsp_txnid_q[RD_LAT-1];
  assign lf_done_o       = done_q;
  assign lf_done_way_o   = done_way_q;
  assign lf_done_index_o = done_index_q;

endmodule

// File: tb/tb_icache_dataram_sched.sv
module tb_icache_dataram_sched;

  localparam int BEAT_NUM   = 4;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;
`ifdef ICACHE_DATARAM_HAZARD_CHK_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_vld, rd_rdy;
  logic [0:0]   rd_way;
  logic [6:0]   rd_index;
  logic [7:0]   rd_txnid;
  logic         lf_vld, lf_rdy;
  logic [0:0]   lf_way;
  logic [6:0]   lf_index;
  logic [127:0] lf_data;
  logic         ram_en, ram_we;
  logic [0:0]   ram_way;
  logic [6:0]   ram_index;
  logic [1:0]   ram_beat;
  logic [127:0] ram_wdata;
  logic         rsp_vld;
  logic [7:0]   rsp_txnid;
  logic         lf_done;
  logic [0:0]   lf_done_way;
  logic [6:0]   lf_done_index;

  int n_tests = 0;
  int n_fail  = 0;

  icache_dataram_sched dut (
    .clk(clk), .rst(rst),
    .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy), .rd_way_i(rd_way),
    .rd_index_i(rd_index), .rd_txnid_i(rd_txnid),
    .lf_vld_i(lf_vld), .lf_rdy_o(lf_rdy), .lf_way_i(lf_way),
    .lf_index_i(lf_index), .lf_data_i(lf_data),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_way_o(ram_way),
    .ram_index_o(ram_index), .ram_beat_o(ram_beat), .ram_wdata_o(ram_wdata),
    .rsp_vld_o(rsp_vld), .rsp_txnid_o(rsp_txnid),
    .lf_done_o(lf_done), .lf_done_way_o(lf_done_way),
    .lf_done_index_o(lf_done_index)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  // ---------------- reference model state (random test) ----------------
  typedef struct { int due; logic [7:0] id; } rsp_t;
  rsp_t       m_q[$];
  bit         m_fill;
  int         m_beats;
  int         m_starve;
  logic [0:0] m_way;
  logic [6:0] m_idx;
  bit         m_done;
  logic [0:0] m_done_way;
  logic [6:0] m_done_idx;
  int         cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_vld = 0; rd_way = 0; rd_index = 0; rd_txnid = 0;
    lf_vld = 0; lf_way = 0; lf_index = 0; lf_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fill = 0; m_beats = 0; m_starve = 0;
    m_way = 0; m_idx = 0;
    m_done = 0; m_done_way = 0; m_done_idx = 0;
  endtask

  // Who gets the array this cycle, from the arbitration rules alone.
  task automatic model_grant(output bit rg, output bit lg);
    rg = 0; lg = 0;
    if (m_fill) begin
      lg = lf_vld;
      rg = rd_vld && !lf_vld && !(HAZ && rd_way == m_way && rd_index == m_idx);
    end else if (rd_vld && lf_vld) begin
      if (m_starve >= STARVE_MAX) lg = 1; else rg = 1;
    end else begin
      rg = rd_vld;
      lg = lf_vld;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
    #3;
    n_tests++;
    if ({ram_en, ram_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ram_ctl: got en/we=%b need 00", {ram_en, ram_we});
    end
    n_tests++;
    if ({ram_way, ram_index, ram_beat} !== '0 || ram_wdata !== '0) begin
      n_fail++; $display("FAIL reset_ram_addr: got way=%0h idx=%0h beat=%0h need 0",
                         ram_way, ram_index, ram_beat);
    end
    n_tests++;
    if ({rsp_vld, rsp_txnid} !== 9'h0) begin
      n_fail++; $display("FAIL reset_rsp: got vld=%b txnid=%0h need 0/0", rsp_vld, rsp_txnid);
    end
    n_tests++;
    if ({lf_done, lf_done_way, lf_done_index} !== 9'h0) begin
      n_fail++; $display("FAIL reset_done: got done=%b way=%0h idx=%0h need 0",
                         lf_done, lf_done_way, lf_done_index);
    end
  endtask

  task automatic test_read_only();
    do_reset();
    rd_vld = 1; rd_way = 1; rd_index = 7'h12; rd_txnid = 8'h5A;
    #3;
    n_tests++;
    if ({rd_rdy, ram_en, ram_we} !== 3'b110) begin
      n_fail++; $display("FAIL rd_cmd: got rdy/en/we=%b need 110", {rd_rdy, ram_en, ram_we});
    end
    n_tests++;
    if ({ram_way, ram_index, ram_beat} !== {1'b1, 7'h12, 2'd0}) begin
      n_fail++; $display("FAIL rd_addr: got way=%0h idx=%0h beat=%0h need 1/12/0",
                         ram_way, ram_index, ram_beat);
    end
    tick();
    rd_vld = 0;
    #3;
    n_tests++;
    if ({rsp_vld, rsp_txnid} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL rd_rsp: got vld=%b txnid=%0h need 1/5a", rsp_vld, rsp_txnid);
    end
    n_tests++;
    if (ram_en !== 1'b0) begin
      n_fail++; $display("FAIL rd_idle_en: got %b need 0", ram_en);
    end
    tick();
    #3;
    n_tests++;
    if (rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp_pulse: got %b need 0", rsp_vld);
    end
  endtask

  task automatic test_fill();
    logic [127:0] d;
    do_reset();
    lf_vld = 1; lf_way = 0; lf_index = 7'h03;
    for (int b = 0; b < BEAT_NUM; b++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      lf_data = d;
      #3;
      n_tests++;
      if ({lf_rdy, ram_en, ram_we, ram_beat, ram_way, ram_index} !==
          {3'b111, 2'(b), 1'b0, 7'h03}) begin
        n_fail++; $display("FAIL fill_beat%0d: got rdy=%b en=%b we=%b beat=%0d idx=%0h need 1/1/1/%0d/03",
                           b, lf_rdy, ram_en, ram_we, ram_beat, ram_index, b);
      end
      n_tests++;
      if (ram_wdata !== d || lf_done !== 1'b0) begin
        n_fail++; $display("FAIL fill_data%0d: got data=%h done=%b need %h/0", b, ram_wdata, lf_done, d);
      end
      tick();
    end
    lf_vld = 0;
    #3;
    n_tests++;
    if ({lf_done, lf_done_way, lf_done_index} !== {1'b1, 1'b0, 7'h03}) begin
      n_fail++; $display("FAIL fill_done: got done=%b way=%0h idx=%0h need 1/0/03",
                         lf_done, lf_done_way, lf_done_index);
    end
    tick();
    #3;
    n_tests++;
    if (lf_done !== 1'b0) begin
      n_fail++; $display("FAIL fill_done_pulse: got %b need 0", lf_done);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    rd_vld = 1; rd_way = 0; rd_index = 7'h01; rd_txnid = 8'h11;
    lf_vld = 1; lf_way = 1; lf_index = 7'h09; lf_data = 128'hABCD;
    for (int c = 0; c < STARVE_MAX; c++) begin
      #3;
      n_tests++;
      if ({rd_rdy, lf_rdy} !== 2'b10) begin
        n_fail++; $display("FAIL starve_rd%0d: got rd_rdy/lf_rdy=%b need 10", c, {rd_rdy, lf_rdy});
      end
      tick();
    end
    #3;
    n_tests++;
    if ({rd_rdy, lf_rdy, ram_we, ram_beat, ram_index} !== {3'b011, 2'd0, 7'h09}) begin
      n_fail++; $display("FAIL starve_force: got rd/lf=%b we=%b beat=%0d idx=%0h need 01/1/0/09",
                         {rd_rdy, lf_rdy}, ram_we, ram_beat, ram_index);
    end
    tick();
    for (int b = 1; b < BEAT_NUM; b++) begin
      #3;
      n_tests++;
      if ({rd_rdy, lf_rdy, ram_beat} !== {2'b01, 2'(b)}) begin
        n_fail++; $display("FAIL starve_burst%0d: got rd/lf=%b beat=%0d need 01/%0d",
                           b, {rd_rdy, lf_rdy}, ram_beat, b);
      end
      tick();
    end
    lf_vld = 0;
    #3;
    n_tests++;
    if (rd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL starve_after_rd: got %b need 1", rd_rdy);
    end
    tick();
    lf_vld = 1;
    #3;
    n_tests++;
    if ({rd_rdy, lf_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL starve_cleared: got rd/lf=%b need 10", {rd_rdy, lf_rdy});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_hazard();
    bit exp_rdy;
    exp_rdy = !HAZ;
    do_reset();
    lf_vld = 1; lf_way = 1; lf_index = 7'h20; lf_data = 128'h1;
    for (int b = 0; b < 2; b++) begin
      #3;
      n_tests++;
      if ({ram_we, ram_beat} !== {1'b1, 2'(b)}) begin
        n_fail++; $display("FAIL haz_beat%0d: got we=%b beat=%0d need 1/%0d", b, ram_we, ram_beat, b);
      end
      tick();
    end
    lf_vld = 0; lf_index = 7'h7F;
    rd_vld = 1; rd_way = 1; rd_index = 7'h21; rd_txnid = 8'h01;
    #3;
    n_tests++;
    if ({rd_rdy, ram_en, ram_we, ram_index} !== {3'b110, 7'h21}) begin
      n_fail++; $display("FAIL haz_other_line: got rdy/en/we=%b idx=%0h need 110/21",
                         {rd_rdy, ram_en, ram_we}, ram_index);
    end
    tick();
    rd_index = 7'h20; rd_txnid = 8'h02;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_tests++;
      if (rd_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL haz_same_line%0d: got rd_rdy=%b need %b", c, rd_rdy, exp_rdy);
      end
      tick();
    end
    lf_vld = 1;
    for (int b = 2; b < BEAT_NUM; b++) begin
      #3;
      n_tests++;
      if ({rd_rdy, lf_rdy, ram_beat, ram_way, ram_index} !== {2'b01, 2'(b), 1'b1, 7'h20}) begin
        n_fail++; $display("FAIL haz_fill%0d: got rd/lf=%b beat=%0d way=%0h idx=%0h need 01/%0d/1/20",
                           b, {rd_rdy, lf_rdy}, ram_beat, ram_way, ram_index, b);
      end
      tick();
    end
    lf_vld = 0;
    #3;
    n_tests++;
    if ({rd_rdy, ram_we, ram_way, ram_index} !== {2'b10, 1'b1, 7'h20}) begin
      n_fail++; $display("FAIL haz_release: got rdy=%b we=%b way=%0h idx=%0h need 1/0/1/20",
                         rd_rdy, ram_we, ram_way, ram_index);
    end
    n_tests++;
    if ({lf_done, lf_done_way, lf_done_index} !== {1'b1, 1'b1, 7'h20}) begin
      n_fail++; $display("FAIL haz_done: got done=%b way=%0h idx=%0h need 1/1/20",
                         lf_done, lf_done_way, lf_done_index);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    lf_vld = 1; lf_way = 0; lf_index = 7'h33; lf_data = 128'h5;
    for (int b = 0; b < 3; b++) tick();
    lf_vld = 0;
    rd_vld = 1; rd_index = 7'h01; rd_txnid = 8'h77;
    rst = 1;
    tick();
    rst = 0;
    rd_vld = 0;
    #3;
    n_tests++;
    if ({rsp_vld, lf_done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_flush: got rsp_vld=%b lf_done=%b need 0/0", rsp_vld, lf_done);
    end
    // In IDLE a non-starved read beats a fill; in FILL it would not.
    rd_vld = 1; lf_vld = 1; lf_way = 1; lf_index = 7'h44;
    #3;
    n_tests++;
    if ({rd_rdy, lf_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL rst_mid_idle: got rd/lf=%b need 10", {rd_rdy, lf_rdy});
    end
    tick();
    rd_vld = 0;
    for (int b = 0; b < BEAT_NUM; b++) begin
      #3;
      n_tests++;
      if ({ram_we, ram_beat, ram_index, lf_done} !== {1'b1, 2'(b), 7'h44, 1'b0}) begin
        n_fail++; $display("FAIL rst_mid_beat%0d: got we=%b beat=%0d idx=%0h done=%b need 1/%0d/44/0",
                           b, ram_we, ram_beat, ram_index, lf_done, b);
      end
      tick();
    end
    lf_vld = 0;
    #3;
    n_tests++;
    if ({lf_done, lf_done_way, lf_done_index} !== {1'b1, 1'b1, 7'h44}) begin
      n_fail++; $display("FAIL rst_mid_done: got done=%b way=%0h idx=%0h need 1/1/44",
                         lf_done, lf_done_way, lf_done_index);
    end
    tick();
  endtask

  task automatic test_random();
    bit         rg, lg, prev_rg, prev_lg, rst_now;
    bit         e_rsp;
    logic [7:0] e_id;
    logic [0:0] e_way;
    logic [6:0] e_idx;
    logic [1:0] e_beat;
    do_reset();
    model_reset();
    cyc = 0; prev_rg = 0; prev_lg = 0; rst_now = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(rd_vld && !prev_rg && !rst_now)) begin
        rd_vld   = ($urandom_range(0, 99) < 60);
        rd_way   = $urandom_range(0, 1) ? m_way : 1'($urandom_range(0, 1));
        rd_index = $urandom_range(0, 1) ? m_idx : 7'($urandom_range(0, 3));
        rd_txnid = 8'($urandom());
      end
      if (!(lf_vld && !prev_lg && !rst_now)) begin
        lf_vld  = ($urandom_range(0, 99) < 50);
        lf_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (!m_fill) begin
          lf_way   = 1'($urandom_range(0, 1));
          lf_index = 7'($urandom_range(0, 3));
        end
      end
      rst_now = ($urandom_range(0, 299) == 0);
      rst = rst_now;
      #3;
      model_grant(rg, lg);
      n_tests++;
      if ({rd_vld && rd_rdy, lf_vld && lf_rdy} !== {rg, lg}) begin
        n_fail++; $display("FAIL rnd_grant c%0d: got rd/lf=%b need %b%b", n,
                           {rd_vld && rd_rdy, lf_vld && lf_rdy}, rg, lg);
      end
      e_way  = lg ? (m_fill ? m_way : lf_way) : (rg ? rd_way : 1'b0);
      e_idx  = lg ? (m_fill ? m_idx : lf_index) : (rg ? rd_index : 7'h0);
      e_beat = lg ? 2'(m_beats) : 2'd0;
      n_tests++;
      if ({ram_en, ram_we, ram_way, ram_index, ram_beat} !== {rg | lg, lg, e_way, e_idx, e_beat} ||
          ram_wdata !== (lg ? lf_data : 128'h0)) begin
        n_fail++; $display("FAIL rnd_ram c%0d: got en=%b we=%b way=%0h idx=%0h beat=%0d need %b/%b/%0h/%0h/%0d",
                           n, ram_en, ram_we, ram_way, ram_index, ram_beat,
                           rg | lg, lg, e_way, e_idx, e_beat);
      end
      e_rsp = (m_q.size() > 0) && (m_q[0].due == cyc);
      e_id  = e_rsp ? m_q[0].id : 8'h0;
      n_tests++;
      if (rsp_vld !== e_rsp || (e_rsp && rsp_txnid !== e_id)) begin
        n_fail++; $display("FAIL rnd_rsp c%0d: got vld=%b txnid=%0h need %b/%0h",
                           n, rsp_vld, rsp_txnid, e_rsp, e_id);
      end
      n_tests++;
      if (lf_done !== m_done ||
          (m_done && {lf_done_way, lf_done_index} !== {m_done_way, m_done_idx})) begin
        n_fail++; $display("FAIL rnd_done c%0d: got done=%b way=%0h idx=%0h need %b/%0h/%0h",
                           n, lf_done, lf_done_way, lf_done_index, m_done, m_done_way, m_done_idx);
      end
      // advance the model to the next cycle
      if (rst_now) begin
        model_reset();
      end else begin
        m_done = 0;
        if (e_rsp) void'(m_q.pop_front());
        if (rg) m_q.push_back('{cyc + RD_LAT, rd_txnid});
        if (lg) begin
          if (!m_fill) begin
            m_way = lf_way;
            m_idx = lf_index;
          end
          m_beats++;
          if (m_beats == BEAT_NUM) begin
            m_done = 1; m_done_way = m_way; m_done_idx = m_idx;
            m_fill = 0; m_beats = 0;
          end else begin
            m_fill = 1;
          end
        end
        if (lf_vld && !lg) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
      end
      prev_rg = rg;
      prev_lg = lg;
      cyc++;
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_read_only();
    test_fill();
    test_starvation();
    test_hazard();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
